fir_sample_fetch: RTL

Upstream feeder for the FIR filter core. On a start pulse it reads sample_count 8-bit samples from the shared sample BRAM, beginning at input_addr. It presents them in address order on a valid/ready stream to the FIR datapath. A small skid FIFO absorbs the BRAM read latency, so backpressure from the FIR (pipelined or non-pipelined) never drops or duplicates a sample.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_sample_fetch_if.sv | 27 ++
 rtl/fir_skid_fifo.sv | 61 ++++++
 rtl/fir_sample_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample fetch and write-back stages.
// Holds bus widths, the fetch FSM state encoding and the write-back base address.
package fir_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 8;
  // Default base address for the sibling write-back stage.
  localparam int OUT_BASE_ADDR = 256;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/fir_sample_fetch_if.sv
// Sample fetch bus: BRAM read port plus the valid/ready sample stream to the FIR core.
// master: the fetch engine (drives mem_en/mem_addr and the stream).
// slave : the BRAM + FIR core side (drives mem_dout and sample_ready).
interface fir_sample_fetch_if #(
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int DATA_W = fir_pkg::DATA_W
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;
  logic              sample_last;

  modport master (
    output mem_en, mem_addr, sample_out, sample_valid, sample_last,
    input  mem_dout, sample_ready
  );

  modport slave (
    input  mem_en, mem_addr, sample_out, sample_valid, sample_last,
    output mem_dout, sample_ready
  );

endinterface

// File: rtl/fir_skid_fifo.sv
// Purpose: small first-word-fall-through FIFO absorbing BRAM read latency.
// Latency: a push becomes visible at pop_dat the cycle after it is written.
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
// Ports: clk/rst, push/push_dat in, pop in, pop_dat = head, count/empty/full status.
module fir_skid_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_dat,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one written, which is safe:
  // the head is read combinationally before the edge overwrites it.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fir_sample_fetch.sv
// Purpose: on start, read sample_count samples from BRAM and stream them in address order.
// Latency: first sample_valid RD_LAT+1 cycles after start; done N+RD_LAT+2 cycles after start.
// Backpressure: reads are credit-limited by FIFO space, so sample_ready=0 never drops data.
// Ports: clk/rst; start/input_addr/sample_count control; busy/done/fetch_count status;
//        bus (master): mem_en/mem_addr/mem_dout BRAM port, sample_out/valid/ready/last stream.
module fir_sample_fetch
  import fir_pkg::*;
#(
  parameter int ADDR_W     = fir_pkg::ADDR_W,
  parameter int DATA_W     = fir_pkg::DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] sample_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fetch_count,
  fir_sample_fetch_if.master bus
);

  // One spare bit so fifo_count + outstanding cannot wrap.
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t state, state_nxt;

  logic [ADDR_W-1:0]                  addr;
  logic [ADDR_W-1:0]                  remaining;
  logic [ADDR_W-1:0]                  latched_count;
  logic [ADDR_W-1:0]                  mem_addr_c;
  logic [CW-1:0]                      outstanding;
  logic [RD_LAT-1:0]                  rd_vld_sr;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;
  logic [DATA_W-1:0]                  fifo_head;
  logic                               fifo_empty;
  logic                               fifo_full;
  logic                               fifo_push;
  logic                               fifo_pop;
  logic                               start_acc;
  logic                               credit;
  logic                               issue;

  assign start_acc = (state == IDLE) && start && !rst;
  assign fifo_pop  = bus.sample_valid && bus.sample_ready;
  assign fifo_push = rd_vld_sr[RD_LAT-1] && (!fifo_full || fifo_pop);

  // Credit: every entry in the FIFO plus every read in flight holds a slot.
  // A same-cycle pop frees its slot at the edge, which keeps one sample per
  // cycle flowing with a 2-deep FIFO at RD_LAT=1.
  assign credit = (CW'(fifo_count) + outstanding) < (DEPTH_C + CW'(fifo_pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. The first read is issued in the start cycle itself, so a
  // single-sample transfer skips FETCH entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (sample_count == '0) begin
            state_nxt = DONE;
          end else if (sample_count == ADDR_W'(1)) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (issue && (remaining == ADDR_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding == '0) && fifo_empty) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    issue      = 1'b0;
    mem_addr_c = addr;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) begin
          mem_addr_c = input_addr;
          issue      = (sample_count != '0) && credit;
        end
      end
      FETCH: begin
        issue = credit;
        busy  = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_en       = issue;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.sample_valid = !fifo_empty;
  assign bus.sample_out   = fifo_empty ? '0 : fifo_head;
  assign bus.sample_last  = bus.sample_valid && (fetch_count == latched_count - ADDR_W'(1));

  // Transfer bookkeeping and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      remaining     <= '0;
      latched_count <= '0;
      fetch_count   <= '0;
      outstanding   <= '0;
      rd_vld_sr     <= '0;
    end else begin
      rd_vld_sr   <= (rd_vld_sr << 1) | RD_LAT'(issue);
      outstanding <= outstanding + CW'(issue) - CW'(rd_vld_sr[RD_LAT-1]);
      if (start_acc) begin
        latched_count <= sample_count;
        addr          <= input_addr;
        remaining     <= sample_count;
      end
      // Address wraps naturally modulo 2^ADDR_W.
      if (issue) begin
        addr      <= mem_addr_c + ADDR_W'(1);
        remaining <= (start_acc ? sample_count : remaining) - ADDR_W'(1);
      end
      if (start_acc) begin
        fetch_count <= '0;
      end else if (fifo_pop) begin
        fetch_count <= fetch_count + ADDR_W'(1);
      end
    end
  end

  fir_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (bus.mem_dout),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule
